pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Sequences the stall/flush controls of the 5-stage pipeline registers (pc, IF/ID, ID/EX, EX/MEM).
//  Detects load-use hazards, holds the pipe for multi-cycle mul/div ops in EX, and inserts
//  redirect bubbles after a taken branch/jump resolves in EX. Also keeps a saturating stall-cycle
//  counter for perf monitoring. Sits beside the datapath; all pipeline register stall/flush pins come from here.
// PARAMETERS
//  REDIRECT_BUBBLES  2     cycles IF/ID+ID/EX are flushed after a redirect (>=1)
//  MD_TIMEOUT        64    max cycles in MD_WAIT before forced abort (>=2)
//  CNT_W             32    width of stall_count
// PORTS
//  clk            in   1      clock, all state updates on posedge
//  rst            in   1      synchronous reset, active-high
//  id_rs1         in   5      rs1 of instr in ID
//  id_rs2         in   5      rs2 of instr in ID
//  id_use_rs1     in   1      ID instr reads rs1
//  id_use_rs2     in   1      ID instr reads rs2
//  ex_rd          in   5      rd of instr in EX
//  ex_mem_read    in   1      EX instr is a load
//  ex_redirect    in   1      taken branch/jump resolved in EX this cycle
//  ex_md_start    in   1      multi-cycle mul/div op entered EX this cycle
//  md_done        in   1      mul/div unit result valid (1-cycle pulse)
//  pc_stall       out  1      hold PC
//  if_id_stall    out  1      hold IF/ID
//  if_id_flush    out  1      zero IF/ID
//  id_ex_stall    out  1      hold ID/EX
//  id_ex_flush    out  1      bubble into ID/EX
//  ex_mem_flush   out  1      bubble into EX/MEM
//  md_timeout     out  1      1-cycle pulse: MD_WAIT aborted by timeout
//  stall_count    out  CNT_W  cycles with pc_stall=1, saturates at all-ones
// BEHAVIOUR
//  - States: RUN, MD_WAIT, REDIRECT. Outputs are Mealy (state + current inputs), no added latency.
//  - rst=1: next state RUN, bubble/timeout counters 0, stall_count 0; all outputs forced 0 while rst=1.
//  - load_use = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
//  - RUN, priority ex_redirect > ex_md_start > load_use:
//    * ex_redirect: if_id_flush=1, id_ex_flush=1 this cycle; if REDIRECT_BUBBLES>1 -> REDIRECT, bub_cnt=REDIRECT_BUBBLES-1.
//    * ex_md_start (no redirect): pc_stall, if_id_stall, id_ex_stall, ex_mem_flush =1; -> MD_WAIT, to_cnt=1.
//      If md_done is also 1 this cycle, outputs are 0 and the state stays RUN (single-cycle op).
//    * load_use: pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly this cycle; state stays RUN.
//  - MD_WAIT: pc_stall, if_id_stall, id_ex_stall, ex_mem_flush =1 every cycle; to_cnt++.
//    * md_done=1: all outputs 0 this cycle (result written to EX/MEM); -> RUN.
//    * to_cnt==MD_TIMEOUT-1 without md_done: md_timeout=1, outputs 0, -> RUN.
//    * ex_redirect, ex_md_start and load_use are ignored in MD_WAIT.
//  - REDIRECT: if_id_flush=1, id_ex_flush=1; bub_cnt--; -> RUN when bub_cnt reaches 0.
//    * A new ex_redirect in REDIRECT reloads bub_cnt=REDIRECT_BUBBLES-1. load_use/ex_md_start are ignored.
//  - stall_count: +1 each cycle pc_stall=1; holds at 2^CNT_W-1.
//  - A flush and a stall on the same register never assert together; when both would apply, flush wins.
//  - rst mid-MD_WAIT/REDIRECT: abandons the operation, and RUN applies on the next cycle.
// TESTING
//  - Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> 1 cycle of pc_stall=if_id_stall=id_ex_flush=1; stall_count=1.
//  - ex_rd=0 with matching rs1 -> no stall. ex_mem_read=0 with a match -> no stall.
//  - MD op: ex_md_start at cycle 0, md_done at cycle 4 -> stalls asserted cycles 0-3, clear at 4; stall_count=4.
//  - Timeout: MD_TIMEOUT=8, ex_md_start and no md_done -> md_timeout pulses at cycle 7; state RUN at cycle 8.
//  - Redirect: REDIRECT_BUBBLES=2, ex_redirect with load_use -> flushes on cycles 0-1, no stall, RUN at cycle 2.
//    A second redirect at cycle 1 extends the flushes through cycle 2.
//  - rst asserted at cycle 2 of MD_WAIT -> outputs 0, stall_count=0, next cycle RUN with no stalls.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, multi-cycle mul/div hold and
// post-redirect bubbles, producing every stall/flush pin of the pipeline registers.
module pipe_hazard_ctrl #(
    parameter int REDIRECT_BUBBLES = 2,
    parameter int MD_TIMEOUT       = 64,
    parameter int CNT_W            = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             ex_md_start,
    input  logic             md_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int BW = $clog2(REDIRECT_BUBBLES) + 1;
    localparam int TW = $clog2(MD_TIMEOUT);
    localparam logic [BW-1:0] BUB_RELOAD = BW'(REDIRECT_BUBBLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MD_WAIT, REDIRECT} state_t;

    state_t           state;
    logic [BW-1:0]    bub_cnt;
    logic [TW-1:0]    to_cnt;
    logic [CNT_W-1:0] cnt_q;
    logic             load_use;
    logic             md_hold;
    logic             lu_hold;
    logic             redir_flush;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    // Mealy decode: outputs react to this cycle's inputs with no added latency.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        md_hold     = 1'b0;
        lu_hold     = 1'b0;
        redir_flush = 1'b0;
        md_timeout  = 1'b0;
        case (state)
            RUN: begin
                if (ex_redirect)                 redir_flush = 1'b1;
                else if (ex_md_start)            md_hold     = !md_done;
                else if (load_use)               lu_hold     = 1'b1;
            end
            MD_WAIT: begin
                if (md_done)                     md_hold     = 1'b0;
                else if (to_cnt == TO_LAST)      md_timeout  = 1'b1;
                else                             md_hold     = 1'b1;
            end
            REDIRECT:                            redir_flush = 1'b1;
            default: ;
        endcase

        if (rst) begin
            md_hold     = 1'b0;
            lu_hold     = 1'b0;
            redir_flush = 1'b0;
            md_timeout  = 1'b0;
        end

        pc_stall     = md_hold || lu_hold;
        if_id_flush  = redir_flush;
        id_ex_flush  = redir_flush || lu_hold;
        ex_mem_flush = md_hold;
        // A flushed register must never also be held.
        if_id_stall  = (md_hold || lu_hold) && !if_id_flush;
        id_ex_stall  = md_hold && !id_ex_flush;
    end

    assign stall_count = rst ? '0 : cnt_q;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state   <= RUN;
            bub_cnt <= '0;
            to_cnt  <= '0;
            cnt_q   <= '0;
        end else begin
            if (pc_stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);

            case (state)
                RUN: begin
                    if (ex_redirect) begin
                        if (REDIRECT_BUBBLES > 1) begin
                            state   <= REDIRECT;
                            bub_cnt <= BUB_RELOAD;
                        end
                    end else if (ex_md_start && !md_done) begin
                        state  <= MD_WAIT;
                        to_cnt <= TW'(1);
                    end
                end
                MD_WAIT: begin
                    if (md_done || (to_cnt == TO_LAST)) begin
                        state  <= RUN;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                REDIRECT: begin
                    if (ex_redirect) begin
                        bub_cnt <= BUB_RELOAD;
                    end else if (bub_cnt <= BW'(1)) begin
                        state   <= RUN;
                        bub_cnt <= '0;
                    end else begin
                        bub_cnt <= bub_cnt - BW'(1);
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule
